// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve countdown, rally stepping, miss detection, scoring and pause.
// Every output is registered; an input event shows its effect one cycle later.
module pong_match_ctrl #(
   parameter int WIN_SCORE   = 7,
   parameter int SERVE_DELAY = 60,
   parameter int PADDLE_LEN  = 16,
   parameter int MIN_H       = 0,
   parameter int MAX_H       = 320
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       start,
   input  logic       pause,
   input  logic [8:0] ball_h,
   input  logic [8:0] ball_y,
   input  logic [8:0] player1_paddle,
   input  logic [8:0] player2_paddle,
   output logic       ball_reset,
   output logic       ball_step,
   output logic       serve_side,
   output logic [3:0] score1,
   output logic [3:0] score2,
   output logic       point_pulse,
   output logic [1:0] winner,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SERVE     = 3'd1,
      PLAY      = 3'd2,
      POINT     = 3'd3,
      PAUSED    = 3'd4,
      GAME_OVER = 3'd5
   } state_t;

   state_t     st;
   logic [7:0] serve_cnt;
   logic       scorer;          // 0: player 1 scored, 1: player 2 scored

   // Paddle spans at 10 bits so a paddle near the bottom never wraps.
   logic [9:0] y10, p1_lo, p1_hi, p2_lo, p2_hi;
   logic       miss1, miss2;

   assign y10   = {1'b0, ball_y};
   assign p1_lo = {1'b0, player1_paddle};
   assign p2_lo = {1'b0, player2_paddle};
   assign p1_hi = p1_lo + 10'(PADDLE_LEN) - 10'd1;
   assign p2_hi = p2_lo + 10'(PADDLE_LEN) - 10'd1;
   assign miss1 = (ball_h == 9'(MIN_H)) && ((y10 < p1_lo) || (y10 > p1_hi));
   assign miss2 = (ball_h == 9'(MAX_H)) && ((y10 < p2_lo) || (y10 > p2_hi));

   assign state = st;

   always_ff @(posedge clock) begin
      if (reset) begin
         st          <= IDLE;
         score1      <= 4'd0;
         score2      <= 4'd0;
         winner      <= 2'b00;
         serve_side  <= 1'b0;
         ball_step   <= 1'b0;
         point_pulse <= 1'b0;
         ball_reset  <= 1'b1;
         serve_cnt   <= 8'd0;
         scorer      <= 1'b0;
      end else begin
         ball_reset  <= 1'b0;
         ball_step   <= 1'b0;
         point_pulse <= 1'b0;
         case (st)
            IDLE, GAME_OVER: begin
               if (start) begin
                  score1     <= 4'd0;
                  score2     <= 4'd0;
                  winner     <= 2'b00;
                  serve_side <= 1'b0;
                  ball_reset <= 1'b1;
                  serve_cnt  <= 8'(SERVE_DELAY);
                  st         <= SERVE;
               end
            end
            SERVE: begin
               if (frame_tick) begin
                  if (serve_cnt <= 8'd1) begin
                     serve_cnt <= 8'd0;
                     st        <= PLAY;
                  end else begin
                     serve_cnt <= serve_cnt - 8'd1;
                  end
               end
            end
            PLAY: begin
               // Pause outranks a coincident frame tick.
               if (pause) begin
                  st <= PAUSED;
               end else if (frame_tick) begin
                  if (miss1) begin
                     scorer      <= 1'b1;
                     serve_side  <= 1'b0;
                     point_pulse <= 1'b1;
                     if (score2 < 4'(WIN_SCORE)) score2 <= score2 + 4'd1;
                     st          <= POINT;
                  end else if (miss2) begin
                     scorer      <= 1'b0;
                     serve_side  <= 1'b1;
                     point_pulse <= 1'b1;
                     if (score1 < 4'(WIN_SCORE)) score1 <= score1 + 4'd1;
                     st          <= POINT;
                  end else begin
                     ball_step <= 1'b1;
                  end
               end
            end
            POINT: begin
               if ((scorer ? score2 : score1) == 4'(WIN_SCORE)) begin
                  winner <= scorer ? 2'b10 : 2'b01;
                  st     <= GAME_OVER;
               end else begin
                  ball_reset <= 1'b1;
                  serve_cnt  <= 8'(SERVE_DELAY);
                  st         <= SERVE;
               end
            end
            PAUSED: begin
               if (pause) st <= PLAY;
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Randomised bench for pong_match_ctrl: a behavioural match model queues expected outputs, a monitor compares.
module tb_pong_match_ctrl;
   localparam int WIN  = 7;
   localparam int SDLY = 5;
   localparam int PLEN = 16;
   localparam int MINH = 0;
   localparam int MAXH = 320;

   logic       clock, reset, frame_tick, start, pause;
   logic [8:0] ball_h, ball_y, player1_paddle, player2_paddle;
   logic       ball_reset, ball_step, serve_side, point_pulse;
   logic [3:0] score1, score2;
   logic [1:0] winner;
   logic [2:0] state;

   pong_match_ctrl #(.WIN_SCORE(WIN), .SERVE_DELAY(SDLY), .PADDLE_LEN(PLEN),
                     .MIN_H(MINH), .MAX_H(MAXH)) dut (
      .clock(clock), .reset(reset), .frame_tick(frame_tick), .start(start), .pause(pause),
      .ball_h(ball_h), .ball_y(ball_y), .player1_paddle(player1_paddle),
      .player2_paddle(player2_paddle), .ball_reset(ball_reset), .ball_step(ball_step),
      .serve_side(serve_side), .score1(score1), .score2(score2), .point_pulse(point_pulse),
      .winner(winner), .state(state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      int st; int s1; int s2; int win; int side; int br; int bs; int pp;
   } exp_t;
   exp_t q[$];

   int n_checks = 0;
   int n_errors = 0;

   // Match model: phase codes are the published state numbers.
   int phase = 0, pts[2] = '{0, 0}, champ = 0, server = 0, ticks_left = 0, last_scorer = 0;

   task automatic chk(input string nm, input int act, input int expv);
      n_checks++;
      if (act != expv) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
      end
   endtask

   function automatic bit outside(input int y, input int top);
      return (y < top) || (y > top + PLEN - 1);
   endfunction

   task automatic model(input bit r, input bit tk, input bit sta, input bit pa,
                        input int h, input int y, input int p1, input int p2);
      exp_t e;
      e.br = 0; e.bs = 0; e.pp = 0;
      if (r) begin
         phase = 0; pts[0] = 0; pts[1] = 0; champ = 0; server = 0; e.br = 1;
      end else if (phase == 0 || phase == 5) begin
         if (sta) begin
            pts[0] = 0; pts[1] = 0; champ = 0; server = 0; e.br = 1;
            ticks_left = SDLY; phase = 1;
         end
      end else if (phase == 1) begin
         if (tk) begin
            ticks_left--;
            if (ticks_left == 0) phase = 2;
         end
      end else if (phase == 2) begin
         if (pa) phase = 4;
         else if (tk) begin
            if (h == MINH && outside(y, p1)) begin
               last_scorer = 1; server = 0;
            end else if (h == MAXH && outside(y, p2)) begin
               last_scorer = 0; server = 1;
            end else begin
               last_scorer = -1;
            end
            if (last_scorer < 0) e.bs = 1;
            else begin
               if (pts[last_scorer] < WIN) pts[last_scorer]++;
               e.pp = 1; phase = 3;
            end
         end
      end else if (phase == 3) begin
         if (pts[last_scorer] == WIN) begin
            champ = last_scorer + 1; phase = 5;
         end else begin
            e.br = 1; ticks_left = SDLY; phase = 1;
         end
      end else if (phase == 4) begin
         if (pa) phase = 2;
      end
      e.st = phase; e.s1 = pts[0]; e.s2 = pts[1]; e.win = champ; e.side = server;
      q.push_back(e);
   endtask

   task automatic cyc(input bit r, input bit tk, input bit sta, input bit pa,
                      input int h, input int y, input int p1, input int p2);
      @(negedge clock);
      reset = r; frame_tick = tk; start = sta; pause = pa;
      ball_h = 9'(h); ball_y = 9'(y); player1_paddle = 9'(p1); player2_paddle = 9'(p2);
      model(r, tk, sta, pa, h, y, p1, p2);
   endtask

   task automatic quiet(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 150, 100, 90, 90);
   endtask

   task automatic serve_out();
      for (int i = 0; i < SDLY; i++) begin
         cyc(0, 1, 0, 0, 150, 100, 90, 90);
         quiet(1);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clock);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("state",       int'(state),       e.st);
            chk("score1",      int'(score1),      e.s1);
            chk("score2",      int'(score2),      e.s2);
            chk("winner",      int'(winner),      e.win);
            chk("serve_side",  int'(serve_side),  e.side);
            chk("ball_reset",  int'(ball_reset),  e.br);
            chk("ball_step",   int'(ball_step),   e.bs);
            chk("point_pulse", int'(point_pulse), e.pp);
         end
      end
   end

   initial begin : stimulus
      int h, y, p1, p2, wait_cyc;
      reset = 1'b1; frame_tick = 1'b0; start = 1'b0; pause = 1'b0;
      ball_h = '0; ball_y = '0; player1_paddle = '0; player2_paddle = '0;
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 150, 100, 90, 90);
      quiet(2);
      // Start, serve countdown, first rally step.
      cyc(0, 0, 1, 0, 150, 100, 90, 90);
      serve_out();
      cyc(0, 1, 0, 0, 150, 100, 90, 90);
      // Paddle hit, then player 1 miss.
      cyc(0, 1, 0, 0, 0, 100, 90, 90);
      cyc(0, 1, 0, 0, 0, 120, 90, 90);
      quiet(3);
      // Player 2 misses until player 1 wins.
      for (int k = 0; k < WIN; k++) begin
         serve_out();
         cyc(0, 1, 0, 0, MAXH, 0, 90, 200);
         quiet(2);
      end
      cyc(0, 1, 0, 0, MAXH, 0, 90, 200);
      quiet(1);
      cyc(0, 0, 1, 0, 150, 100, 90, 90);
      // Pause colliding with a frame tick.
      serve_out();
      cyc(0, 1, 0, 1, 0, 300, 90, 90);
      for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 300, 90, 90);
      cyc(0, 0, 0, 1, 150, 100, 90, 90);
      cyc(0, 1, 0, 0, 150, 100, 90, 90);
      // Reset mid-serve with player 2 on 3.
      for (int k = 0; k < 3; k++) begin
         serve_out();
         cyc(0, 1, 0, 0, 0, 500, 90, 90);
         quiet(2);
      end
      cyc(0, 1, 0, 0, 150, 100, 90, 90);
      cyc(1, 0, 0, 0, 150, 100, 90, 90);
      quiet(2);
      // Randomised traffic.
      for (int i = 0; i < 4000; i++) begin
         p1 = $urandom_range(0, 300);
         p2 = $urandom_range(0, 300);
         case ($urandom_range(0, 3))
            0: begin h = MINH; y = p1 + int'($urandom_range(0, 40)) - 12; end
            1: begin h = MAXH; y = p2 + int'($urandom_range(0, 40)) - 12; end
            default: begin h = $urandom_range(1, 319); y = $urandom_range(0, 511); end
         endcase
         if (y < 0) y = 0;
         if (y > 511) y = 511;
         cyc($urandom_range(0, 399) == 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 29) == 0, $urandom_range(0, 24) == 0, h, y, p1, p2);
      end
      wait_cyc = 0;
      while (q.size() > 0 && wait_cyc < 10) begin
         @(negedge clock);
         wait_cyc++;
      end
      chk("queue_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
